// File: rtl/comb_edge_scheduler.sv
`default_nettype none
// comb_edge_scheduler: clears the ADJ rows, then walks the COO edge list and
// issues one accumulate-write per edge direction, guarded by done_trans.
module comb_edge_scheduler #(
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_BW            = 3,
  parameter int FEATURE_ROWS      = 6,
  parameter int UNDIRECTED        = 1,
  parameter int FEATURE_WIDTH     = $clog2(FEATURE_ROWS),
  parameter int COO_ADDRESS_WIDTH = $clog2(COO_NUM_OF_COLS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         done_trans,
  input  logic [2*COO_BW-1:0]          coo_in,
  output logic [COO_ADDRESS_WIDTH-1:0] coo_address,
  output logic [FEATURE_WIDTH-1:0]     edge_src,
  output logic [FEATURE_WIDTH-1:0]     edge_dst,
  output logic                         swap_src_dst,
  output logic                         enable_write_adj,
  output logic                         clear_adj,
  output logic [FEATURE_WIDTH-1:0]     clear_row,
  output logic                         busy,
  output logic                         done_comb,
  output logic                         coo_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_FWD   = 3'd3;
  localparam logic [2:0] S_REV   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [COO_ADDRESS_WIDTH-1:0] C_LAST_COL = COO_ADDRESS_WIDTH'(COO_NUM_OF_COLS - 1);
  localparam logic [FEATURE_WIDTH-1:0]     C_LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COO_BW:0]              C_ROWS     = (COO_BW + 1)'(FEATURE_ROWS);
  localparam logic [COO_BW-1:0]            C_ONE      = COO_BW'(1);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [COO_BW-1:0] src_field;
  logic [COO_BW-1:0] dst_field;
  logic              fetch_ok;
  logic              last_col;
  logic              do_rev;
  logic [2:0]        after_edge;

  assign src_field  = coo_in[2*COO_BW-1:COO_BW];
  assign dst_field  = coo_in[COO_BW-1:0];
  // Fields are 1-indexed: 0 and anything beyond the node count are rejected.
  assign fetch_ok   = (src_field != '0) && ({1'b0, src_field} <= C_ROWS) &&
                      (dst_field != '0) && ({1'b0, dst_field} <= C_ROWS);
  assign last_col   = (coo_address == C_LAST_COL);
  assign do_rev     = (UNDIRECTED != 0) && (edge_src != edge_dst);
  assign after_edge = last_col ? S_DONE : S_FETCH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (done_trans) next_state = S_CLEAR;
      S_CLEAR: begin
        if (!done_trans)                 next_state = S_IDLE;
        else if (clear_row == C_LAST_ROW) next_state = S_FETCH;
      end
      S_FETCH: begin
        if (!done_trans)    next_state = S_IDLE;
        else if (!fetch_ok) next_state = after_edge;
        else                next_state = S_FWD;
      end
      S_FWD: begin
        if (!done_trans)  next_state = S_IDLE;
        else if (do_rev)  next_state = S_REV;
        else              next_state = after_edge;
      end
      S_REV: begin
        if (!done_trans) next_state = S_IDLE;
        else             next_state = after_edge;
      end
      S_DONE:  if (!done_trans) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    clear_adj        = 1'b0;
    enable_write_adj = 1'b0;
    swap_src_dst     = 1'b0;
    busy             = 1'b0;
    done_comb        = 1'b0;
    case (state)
      S_CLEAR: begin
        clear_adj = 1'b1;
        busy      = 1'b1;
      end
      S_FETCH: busy = 1'b1;
      S_FWD: begin
        enable_write_adj = 1'b1;
        busy             = 1'b1;
      end
      S_REV: begin
        enable_write_adj = 1'b1;
        swap_src_dst     = 1'b1;
        busy             = 1'b1;
      end
      S_DONE:  done_comb = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coo_address <= '0;
      edge_src    <= '0;
      edge_dst    <= '0;
      clear_row   <= '0;
      coo_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (done_trans) begin
            clear_row <= '0;
            coo_err   <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (done_trans) begin
            if (clear_row == C_LAST_ROW) coo_address <= '0;
            else                         clear_row   <= clear_row + FEATURE_WIDTH'(1);
          end
        end
        S_FETCH: begin
          if (done_trans) begin
            edge_src <= FEATURE_WIDTH'(src_field - C_ONE);
            edge_dst <= FEATURE_WIDTH'(dst_field - C_ONE);
            if (!fetch_ok) begin
              coo_err <= 1'b1;
              if (!last_col) coo_address <= coo_address + COO_ADDRESS_WIDTH'(1);
            end
          end
        end
        S_FWD: begin
          if (done_trans && !do_rev && !last_col)
            coo_address <= coo_address + COO_ADDRESS_WIDTH'(1);
        end
        S_REV: begin
          if (done_trans && !last_col)
            coo_address <= coo_address + COO_ADDRESS_WIDTH'(1);
        end
        S_DONE: begin
          if (!done_trans) coo_address <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comb_edge_scheduler.sv
`default_nettype none
// tb_comb_edge_scheduler: randomized and directed checks against a trace-level model.
module tb_comb_edge_scheduler;
  localparam int E = 6, BW = 3, FR = 6, FW = 3, AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done_trans = 1'b0;
  always #5 clk = ~clk;

  logic [BW-1:0] tbl_src [8];
  logic [BW-1:0] tbl_dst [8];

  logic [2*BW-1:0] coo_in1, coo_in2;
  logic [AW-1:0] addr1, addr2;
  logic [FW-1:0] src1, dst1, row1, src2, dst2, row2;
  logic sw1, we1, clr1, busy1, done1, err1;
  logic sw2, we2, clr2, busy2, done2, err2;

  assign coo_in1 = {tbl_src[addr1], tbl_dst[addr1]};
  assign coo_in2 = {tbl_src[addr2], tbl_dst[addr2]};

  comb_edge_scheduler #(.COO_NUM_OF_COLS(E), .COO_BW(BW), .FEATURE_ROWS(FR), .UNDIRECTED(1)) dut1 (
    .clk(clk), .reset(reset), .done_trans(done_trans), .coo_in(coo_in1),
    .coo_address(addr1), .edge_src(src1), .edge_dst(dst1), .swap_src_dst(sw1),
    .enable_write_adj(we1), .clear_adj(clr1), .clear_row(row1), .busy(busy1),
    .done_comb(done1), .coo_err(err1));

  comb_edge_scheduler #(.COO_NUM_OF_COLS(E), .COO_BW(BW), .FEATURE_ROWS(FR), .UNDIRECTED(0)) dut2 (
    .clk(clk), .reset(reset), .done_trans(done_trans), .coo_in(coo_in2),
    .coo_address(addr2), .edge_src(src2), .edge_dst(dst2), .swap_src_dst(sw2),
    .enable_write_adj(we2), .clear_adj(clr2), .clear_row(row2), .busy(busy2),
    .done_comb(done2), .coo_err(err2));

  int n_cmp = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected per-cycle behaviour of one started run, derived from the edge list.
  typedef struct {
    bit clr; int row; bit we; bit sw; int src; int dst; int addr; bit busy; bit done; bit bad;
  } rec_t;
  rec_t trace [64];

  function automatic rec_t mk(bit clr, int row, bit we, bit sw, int src, int dst,
                              int addr, bit busy, bit done, bit bad);
    rec_t r;
    r.clr = clr; r.row = row; r.we = we; r.sw = sw; r.src = src; r.dst = dst;
    r.addr = addr; r.busy = busy; r.done = done; r.bad = bad;
    return r;
  endfunction

  task automatic build_trace(input int u, output int n_we, output int done_idx);
    int n = 0;
    n_we = 0;
    for (int r = 0; r < FR; r++) begin
      trace[n] = mk(1, r, 0, 0, 0, 0, -1, 1, 0, 0); n++;
    end
    for (int i = 0; i < E; i++) begin
      int s = int'(tbl_src[i]);
      int d = int'(tbl_dst[i]);
      bit ok = (s >= 1) && (s <= FR) && (d >= 1) && (d <= FR);
      trace[n] = mk(0, 0, 0, 0, 0, 0, i, 1, 0, !ok); n++;
      if (ok) begin
        trace[n] = mk(0, 0, 1, 0, s - 1, d - 1, i, 1, 0, 0); n++; n_we++;
        if (u != 0 && s != d) begin
          trace[n] = mk(0, 0, 1, 1, s - 1, d - 1, i, 1, 0, 0); n++; n_we++;
        end
      end
    end
    trace[n] = mk(0, 0, 0, 0, 0, 0, E - 1, 0, 1, 0);
    done_idx = n;
  endtask

  bit m_run = 0, m_err = 0, m_known = 1;
  int m_idx = 0;

  initial forever begin
    int t1, t2;
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_run = 0; m_err = 0; m_known = 1;
    end else if (!m_run) begin
      if (done_trans) begin
        build_trace(1, t1, t2);
        m_run = 1; m_idx = 0; m_err = 0;
      end
    end else if (!done_trans) begin
      m_known = trace[m_idx].done;
      m_run = 0;
    end else begin
      if (trace[m_idx].bad) m_err = 1;
      if (!trace[m_idx].done) m_idx++;
    end
  end

  initial forever @(posedge clk) cyc++;

  initial forever begin
    rec_t r;
    @(negedge clk);
    if (m_run) begin
      r = trace[m_idx];
      chk("clear_adj", clr1, r.clr);
      chk("enable_write_adj", we1, r.we);
      chk("swap_src_dst", sw1, r.sw);
      chk("busy", busy1, r.busy);
      chk("done_comb", done1, r.done);
      chk("coo_err", err1, m_err);
      if (r.clr) chk("clear_row", row1, r.row);
      if (r.we) begin
        chk("edge_src", src1, r.src);
        chk("edge_dst", dst1, r.dst);
      end
      if (r.addr >= 0) chk("coo_address", addr1, r.addr);
    end else begin
      chk("idle_outputs", {clr1, we1, sw1, busy1, done1}, 0);
      chk("idle_coo_err", err1, m_err);
      if (m_known) chk("idle_coo_address", addr1, 0);
    end
  end

  int cnt_clr, cnt_we, cnt_sw, cnt_we2, cnt_sw2, lat1, lat2, drv_cyc;
  initial forever begin
    @(negedge clk);
    if (clr1) cnt_clr++;
    if (we1) cnt_we++;
    if (sw1) cnt_sw++;
    if (we2) cnt_we2++;
    if (sw2) cnt_sw2++;
    if (done1 && lat1 < 0) lat1 = cyc - drv_cyc;
    if (done2 && lat2 < 0) lat2 = cyc - drv_cyc;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cnt_clr = 0; cnt_we = 0; cnt_sw = 0; cnt_we2 = 0; cnt_sw2 = 0;
    lat1 = -1; lat2 = -1; drv_cyc = cyc;
  endtask

  task automatic set_default();
    int ds [6] = '{1, 1, 2, 3, 4, 5};
    int dd [6] = '{2, 3, 4, 5, 6, 6};
    for (int i = 0; i < 8; i++) begin
      tbl_src[i] = (i < 6) ? BW'(ds[i]) : '0;
      tbl_dst[i] = (i < 6) ? BW'(dd[i]) : '0;
    end
  endtask

  function automatic logic [BW-1:0] rnd_field();
    int p = int'($urandom_range(0, 9));
    if (p < 8) return BW'($urandom_range(1, FR));
    else if (p == 8) return '0;
    else return BW'(7);
  endfunction

  task automatic wait_done();
    for (int i = 0; i < 100 && !done1; i++) tick();
  endtask

  task automatic run_full(input int e_we, input int e_sw, input int e_lat,
                          input int e_we2, input int e_lat2, input int e_err);
    clear_counts();
    done_trans = 1'b1;
    wait_done();
    chk("done_latency", lat1, e_lat);
    chk("clear_strobes", cnt_clr, FR);
    chk("write_strobes", cnt_we, e_we);
    chk("swap_strobes", cnt_sw, e_sw);
    chk("coo_err_at_done", err1, e_err);
    chk("directed_writes", cnt_we2, e_we2);
    chk("directed_swaps", cnt_sw2, 0);
    chk("directed_latency", lat2, e_lat2);
  endtask

  task automatic stop_run();
    done_trans = 1'b0;
    tick(); tick();
  endtask

  initial begin
    int nwe, didx;
    bit found;
    set_default();
    tick(); tick(); tick();
    chk("reset_outputs", {addr1, src1, dst1, sw1, we1, clr1, row1, busy1, done1, err1}, 0);
    chk("reset_outputs_directed", {addr2, src2, dst2, sw2, we2, clr2, row2, busy2, done2, err2}, 0);
    reset = 1'b1;
    tick(); tick(); tick();
    chk("no_strobe_after_release", {clr1, we1, clr2, we2}, 0);

    build_trace(1, nwe, didx);
    chk("model_done_index_undirected", didx, 24);
    chk("model_writes_undirected", nwe, 12);
    build_trace(0, nwe, didx);
    chk("model_done_index_directed", didx, 18);
    chk("model_writes_directed", nwe, 6);

    run_full(12, 6, 25, 6, 19, 0);
    stop_run();
    chk("addr_after_done", addr1, 0);

    tbl_src[2] = 3'd4; tbl_dst[2] = 3'd4;
    run_full(11, 5, 24, 6, 19, 0);
    stop_run();
    set_default();

    tbl_src[1] = 3'd0; tbl_dst[1] = 3'd3;
    run_full(10, 5, 23, 5, 18, 1);
    stop_run();
    chk("coo_err_sticky_idle", err1, 1);
    tbl_src[1] = 3'd7; tbl_dst[1] = 3'd1;
    run_full(10, 5, 23, 5, 18, 1);
    stop_run();
    set_default();

    // Abort during the forward write of edge 2.
    clear_counts();
    done_trans = 1'b1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (we1 && !sw1 && addr1 == 3'd1) begin found = 1; break; end
    end
    chk("abort_point_reached", found, 1);
    done_trans = 1'b0;
    clear_counts();
    repeat (8) tick();
    chk("strobes_after_abort", cnt_we + cnt_clr + lat1 + 1, 0);
    done_trans = 1'b1;
    tick();
    chk("restart_clear_row0", {clr1, row1}, 8);
    stop_run();

    // Reset in the reverse write of edge 4, then restart with done_trans held.
    clear_counts();
    done_trans = 1'b1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (sw1 && addr1 == 3'd3) begin found = 1; break; end
    end
    chk("reset_point_reached", found, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {addr1, src1, dst1, sw1, we1, clr1, row1, busy1, done1, err1}, 0);
    tick(); tick();
    reset = 1'b1;
    clear_counts();
    wait_done();
    chk("restart_latency", lat1, 25);
    chk("restart_writes", cnt_we, 12);
    stop_run();

    for (int run = 0; run < 25; run++) begin
      for (int i = 0; i < E; i++) begin
        tbl_src[i] = rnd_field();
        tbl_dst[i] = rnd_field();
      end
      done_trans = 1'b1;
      repeat ($urandom_range(2, 32)) tick();
      done_trans = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
